// File: rtl/rr_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rr_mux_pkg: shared constants, lock-state type, one-hot decode  |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
package rr_mux_pkg;

  localparam int N_CH      = 4;
  localparam int SEL_W     = 2;
  localparam int W_DEFAULT = 8;

  typedef enum logic [0:0] {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_CH-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb4.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rr_arb4: rotating-priority 4-way arbiter with pointer register |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module rr_arb4
  import rr_mux_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            en,
  output logic [N_CH-1:0] grant
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < N_CH; k++) begin
      idx = ptr + SEL_W'(k);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= onehot_to_idx(grant) + SEL_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_mux_4x1.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rr_mux_4x1: round-robin 4:1 stream mux, registered output      |
// | Option: RR_MUX_LAST_LOCK_EN adds packet locking on in_last     |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module rr_mux_4x1
  import rr_mux_pkg::*;
#(
  parameter int W = W_DEFAULT
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
`ifdef RR_MUX_LAST_LOCK_EN
  input  logic [N_CH-1:0]   in_last,
  output logic              out_last,
`endif
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel,
  input  logic              out_ready
);

  logic             load_en;
  logic             arb_en;
  logic             xfer;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] gsel;
  logic [W-1:0]     gdata;

  assign load_en = !out_valid | out_ready;
  // Gating with rst keeps in_ready low for the whole reset pulse.
  assign arb_en  = load_en & !rst;

`ifdef RR_MUX_LAST_LOCK_EN
  localparam logic [0:0] ST_IDLE   = LOCK_IDLE;
  localparam logic [0:0] ST_LOCKED = LOCK_LOCKED;

  logic [0:0]       lock_state;
  logic [SEL_W-1:0] lock_ch;

  assign req = (lock_state == ST_LOCKED) ? (in_valid & (N_CH'(1) << lock_ch)) : in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state <= ST_IDLE;
      lock_ch    <= '0;
      out_last   <= 1'b0;
    end else if (load_en) begin
      out_last <= xfer & in_last[gsel];
      if (xfer) begin
        lock_ch    <= gsel;
        lock_state <= in_last[gsel] ? ST_IDLE : ST_LOCKED;
      end
    end
  end
`else
  assign req = in_valid;
`endif

  rr_arb4 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .en    (arb_en),
    .grant (grant)
  );

  assign in_ready = grant;
  assign xfer     = |grant;
  assign gsel     = onehot_to_idx(grant);

  always_comb begin
    gdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) gdata = gdata | in_data[i*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= gdata;
        out_sel  <= gsel;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/rr_mux_4x1.md
RR_MUX_4X1 -- requirements
Module: rr_mux_4x1

Interface
REQ-001 SHALL have parameter: W, 8, data width of each channel in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  4  per-channel beat-valid, bit i = channel i.
REQ-005 SHALL have port: in_data  input  4*W  channel i data at bits [i*W +: W].
REQ-006 SHALL have port: in_ready  output  4  per-channel accept, one-hot or zero.
REQ-007 SHALL have port: out_valid  output  1  output register holds a beat.
REQ-008 SHALL have port: out_data  output  W  registered data of the granted channel.
REQ-009 SHALL have port: out_sel  output  2  index of the channel that sourced out_data.
REQ-010 SHALL have port: out_ready  input  1  downstream accept.

Function
REQ-011 SHALL define a transfer as valid&ready high on the same rising edge, on either side.
REQ-012 SHALL assert load_en = !out_valid | out_ready, combinationally.
REQ-013 SHALL, when load_en is high, grant the first requesting channel found scanning from ptr upward, modulo 4.
REQ-014 SHALL drive in_ready[g] = load_en & in_valid[g] for grant g, with all other bits 0, so at most one input transfers per cycle.
REQ-015 SHALL, on an input transfer, load out_data, out_sel=g and out_valid=1 on that edge, giving one-cycle latency and a throughput of one beat per cycle.
REQ-016 SHALL clear out_valid when load_en is high and in_valid==0.
REQ-017 SHALL hold out_valid, out_data and out_sel stable while out_valid & !out_ready.
REQ-018 SHALL update ptr to (g+1) mod 4 after a grant, so 3 wraps to 0, and SHALL leave ptr unchanged when there is no grant.
REQ-019 SHALL allow simultaneous output drain and input load in one cycle, with no bubble.
REQ-020 SHALL permit in_ready to depend combinationally on out_ready and in_valid, with no combinational path from in_data to any output.

Reset
REQ-021 SHALL on rst force out_valid=0, out_data=0, out_sel=0, ptr=0 and lock state IDLE, independent of clk.
REQ-022 SHALL discard any beat held in the output register when rst asserts mid-stream, and SHALL hold in_ready=0 while rst is high.

Configuration
REQ-023 SHALL, with RR_MUX_LAST_LOCK_EN defined, add ports in_last (input, 4) and out_last (output, 1, registered with the data, reset 0).
REQ-024 SHALL, with RR_MUX_LAST_LOCK_EN defined, implement FSM IDLE/LOCKED: a transfer with in_last=0 moves to LOCKED on the granted channel; while LOCKED only that channel may be granted; a transfer with in_last=1 returns to IDLE and advances ptr.
REQ-025 SHALL, without RR_MUX_LAST_LOCK_EN, re-arbitrate every beat and have no last ports and no FSM.

Structure
REQ-026 SHALL place N_CH=4, SEL_W=2, the default W and the lock-state enum in package rr_mux_pkg.
REQ-027 SHALL implement the rotating-priority search and ptr register in sub-module rr_arb4, with request (4), enable and grant (one-hot 4) ports.

Verification
REQ-028 SHALL verify: reset is released with all in_valid=0 -> out_valid=0, in_ready=0000, out_sel=0.
REQ-029 SHALL verify: in_valid=1111 with data A0,B1,C2,D3 on channels 0-3 and out_ready=1 held -> out_sel sequence 0,1,2,3,0 on consecutive cycles with matching data.
REQ-030 SHALL verify: only channel 2 is valid with data 5A and out_ready=0 for 3 cycles -> out_data=5A held stable, in_ready=0000 after the first load, then one drain and no duplicate.
REQ-031 SHALL verify: ptr=3 with requests 1001 -> channel 3 is granted, then channel 0 (wrap).
REQ-032 SHALL verify: rst is pulsed asynchronously between clock edges while out_valid=1 -> out_valid drops immediately and the first grant after release goes to channel 0.
REQ-033 SHALL verify, with RR_MUX_LAST_LOCK_EN defined: channel 1 sends a 3-beat packet while channel 0 is valid -> beats 1,1,1 are output with out_last on the third beat, then channel 0 is granted.
